// File: rtl/cbx_ccff_loader.sv
// cbx_ccff_loader: serial loader for one connection block's configuration chain.
// Words from the bitstream are shifted LSB-first into the chain head. The bits
// leaving the chain tail are collected into readback words, so the previous
// configuration can be checked. A readback word that has not been taken stalls
// further shifting.
module cbx_ccff_loader #(
   parameter int CHAIN_LEN = 36,
   parameter int WORD_W    = 8,
   parameter int CNT_W     = 6
) (
   input  logic              prog_clk,
   input  logic              prog_rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [WORD_W-1:0] bs_data,
   input  logic              bs_valid,
   output logic              bs_ready,
   output logic              ccff_head,
   input  logic              ccff_tail,
   output logic              shift_en,
   output logic [WORD_W-1:0] rb_data,
   output logic              rb_valid,
   input  logic              rb_ready,
   output logic              busy,
   output logic              cfg_done
);

   localparam int WB_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  bit_cnt;
   logic [WB_W-1:0]   word_bit;
   logic [WORD_W-1:0] word_sr;
   logic [WORD_W-1:0] rb_sr;
   logic [WORD_W-1:0] rb_next;
   logic              accept;
   logic              last_bit;
   logic              word_end;
   logic              do_start;

   // Decode helper conditions and the readback word including the bit sampled this edge.
   always_comb begin
      accept   = bs_ready && bs_valid;
      last_bit = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
      word_end = (word_bit == WB_W'(WORD_W - 1));
      do_start = start && ((state == S_IDLE) || (state == S_DONE));
      rb_next  = rb_sr;
      // The tail bit is sampled before the chain shifts on the same edge.
      rb_next[word_bit] = ccff_tail;
   end

   // State register.
   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         state <= S_IDLE;
      end else begin
         // NOTE: sequential state is updated with non-blocking assignments, so every
         // process triggered by this edge sees the pre-edge values.
         state <= state_nxt;
      end
   end

   // Next-state decode and state-derived outputs.
   always_comb begin
      // NOTE: every output gets a default before the case; a path that leaves one
      // unassigned would infer a latch.
      state_nxt = state;
      bs_ready  = 1'b0;
      shift_en  = 1'b0;
      ccff_head = 1'b0;
      busy      = 1'b0;
      cfg_done  = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_LOAD;
         end
         S_LOAD: begin
            bs_ready = 1'b1;
            busy     = 1'b1;
            if (bs_valid) state_nxt = S_SHIFT;
         end
         S_SHIFT: begin
            busy      = 1'b1;
            ccff_head = word_sr[0];
            // An untaken readback word freezes the chain; nothing may be lost.
            shift_en  = !rb_valid;
            if (!rb_valid && (word_end || last_bit)) begin
               state_nxt = last_bit ? S_DONE : S_LOAD;
            end
         end
         S_DONE: begin
            // Completion is reported only after the final readback word has been taken.
            cfg_done = !rb_valid;
            if (start) state_nxt = S_LOAD;
         end
         default: state_nxt = S_IDLE;
      endcase
      // Abort overrides everything, including a simultaneous start.
      if (abort) state_nxt = S_IDLE;
   end

   // Datapath: word and readback shift registers, counters, readback handshake.
   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         // NOTE: all datapath registers are small flops rather than a memory, so they
         // are cleared by the asynchronous reset along with the state.
         bit_cnt  <= '0;
         word_bit <= '0;
         word_sr  <= '0;
         rb_sr    <= '0;
         rb_data  <= '0;
         rb_valid <= 1'b0;
      end else if (abort) begin
         rb_valid <= 1'b0;
      end else begin
         if (rb_valid && rb_ready) rb_valid <= 1'b0;
         if (do_start) bit_cnt <= '0;
         if (accept) begin
            word_sr  <= bs_data;
            word_bit <= '0;
            rb_sr    <= '0;
         end
         if (shift_en) begin
            word_sr  <= word_sr >> 1;
            rb_sr    <= rb_next;
            word_bit <= word_bit + WB_W'(1);
            bit_cnt  <= bit_cnt + CNT_W'(1);
            // Setting here overrides the release above, so a handshake and a new
            // word on the same edge leave no bubble.
            if (word_end || last_bit) begin
               rb_data  <= rb_next;
               rb_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_cbx_ccff_loader.sv
// Testbench for cbx_ccff_loader: a behavioural chain model is attached to head/tail.
// Expected readback words are queued when the chain is preloaded and compared
// against the words the DUT actually hands over.
module tb_cbx_ccff_loader;

   localparam int CHAIN_LEN = 36;
   localparam int WORD_W    = 8;
   localparam int CNT_W     = 6;

   logic              prog_clk   = 1'b0;
   logic              prog_rst_n = 1'b0;
   logic              start      = 1'b0;
   logic              abort      = 1'b0;
   logic [WORD_W-1:0] bs_data    = '0;
   logic              bs_valid   = 1'b0;
   logic              bs_ready;
   logic              ccff_head;
   logic              ccff_tail;
   logic              shift_en;
   logic [WORD_W-1:0] rb_data;
   logic              rb_valid;
   logic              rb_ready   = 1'b0;
   logic              busy;
   logic              cfg_done;

   cbx_ccff_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
      .prog_clk  (prog_clk),
      .prog_rst_n(prog_rst_n),
      .start     (start),
      .abort     (abort),
      .bs_data   (bs_data),
      .bs_valid  (bs_valid),
      .bs_ready  (bs_ready),
      .ccff_head (ccff_head),
      .ccff_tail (ccff_tail),
      .shift_en  (shift_en),
      .rb_data   (rb_data),
      .rb_valid  (rb_valid),
      .rb_ready  (rb_ready),
      .busy      (busy),
      .cfg_done  (cfg_done)
   );

   always #5 prog_clk = ~prog_clk;

   // Chain model: bits enter at the head (bit 35) and leave at the tail (bit 0).
   logic [35:0] chain       = '0;
   logic        preload_req = 1'b0;
   logic [35:0] preload_val = '0;
   always @(posedge prog_clk) begin
      if (preload_req)   chain <= preload_val;
      else if (shift_en) chain <= {ccff_head, chain[35:1]};
   end
   assign ccff_tail = chain[0];

   // Monitor: counts shift edges and bitstream handshakes, records readback words.
   int         shift_cnt = 0;
   int         hs_cnt    = 0;
   int         obs_cnt   = 0;
   logic [7:0] obs_mem [0:255];
   always @(negedge prog_clk) begin
      if (prog_rst_n) begin
         if (shift_en) shift_cnt++;
         if (bs_valid && bs_ready) hs_cnt++;
         if (rb_valid && rb_ready && obs_cnt < 256) begin
            obs_mem[obs_cnt] = rb_data;
            obs_cnt++;
         end
      end
   end

   int         n_cmp   = 0;
   int         n_fail  = 0;
   int         rd_idx  = 0;
   bit         aborted = 1'b0;
   logic [7:0] exp_q [$];
   logic [7:0] load_words [5] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h09};
   localparam logic [35:0] LOAD_PATTERN = 36'h9_00FF_3CA5;

   // Loads the chain model and queues the readback words it must produce.
   task automatic preload(input logic [35:0] v);
      logic [39:0] t;
      t = {4'h0, v};
      preload_val = v;
      preload_req = 1'b1;
      @(posedge prog_clk); #1;
      preload_req = 1'b0;
      for (int k = 0; k < 5; k++) exp_q.push_back(t[8*k +: 8]);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge prog_clk); #1;
      start = 1'b0;
   endtask

   // Offers one word; with gap>0 waits for LOAD and idles gap cycles first.
   task automatic send_word(input logic [7:0] w, input int gap);
      bit ok;
      ok = 1'b0;
      if (gap > 0) begin
         for (int i = 0; i < 200 && !bs_ready && !aborted; i++) begin
            @(posedge prog_clk); #1;
         end
         for (int g = 0; g < gap && !aborted; g++) begin
            n_cmp++;
            if (bs_ready !== 1'b1 || shift_en !== 1'b0) begin
               n_fail++;
               $display("FAIL gap_hold: bs_ready=%b shift_en=%b, required 1/0", bs_ready, shift_en);
            end
            @(posedge prog_clk); #1;
         end
      end
      bs_data  = w;
      bs_valid = 1'b1;
      for (int i = 0; i < 200 && !ok && !aborted; i++) begin
         @(negedge prog_clk);
         if (bs_ready) ok = 1'b1;
         @(posedge prog_clk); #1;
      end
      bs_valid = 1'b0;
      if (!ok && !aborted) begin
         n_cmp++;
         n_fail++;
         $display("FAIL bs_handshake_timeout: word %h not accepted, required acceptance", w);
      end
   endtask

   task automatic feed(input int gap);
      for (int k = 0; k < 5; k++) begin
         if (!aborted) send_word(load_words[k], gap);
      end
   endtask

   task automatic wait_done(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(posedge prog_clk); #1;
         if (cfg_done) seen = 1'b1;
      end
      n_cmp++;
      if (!seen) begin
         n_fail++;
         $display("FAIL %s_done_timeout: cfg_done=0, required 1", name);
      end
   endtask

   task automatic test_reset();
      #12;
      n_cmp++;
      if ({bs_ready, ccff_head, shift_en, rb_valid, busy, cfg_done} !== 6'b0 || rb_data !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_outputs: ctrl=%b rb_data=%h, required 000000/00",
                  {bs_ready, ccff_head, shift_en, rb_valid, busy, cfg_done}, rb_data);
      end
      @(posedge prog_clk); #1;
      prog_rst_n = 1'b1;
      rb_ready   = 1'b1;
      @(posedge prog_clk); #1;
      n_cmp++;
      if (busy !== 1'b0 || bs_ready !== 1'b0 || cfg_done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: busy=%b bs_ready=%b cfg_done=%b, required 0/0/0", busy, bs_ready, cfg_done);
      end
   endtask

   task automatic test_full_load();
      int s0, h0;
      logic [7:0] e;
      preload(36'h0_1234_5678);
      s0 = shift_cnt;
      h0 = hs_cnt;
      pulse_start();
      feed(0);
      wait_done("full");
      n_cmp++;
      if (shift_cnt - s0 !== CHAIN_LEN) begin
         n_fail++;
         $display("FAIL full_shift_count: got %0d, required %0d", shift_cnt - s0, CHAIN_LEN);
      end
      n_cmp++;
      if (hs_cnt - h0 !== 5) begin
         n_fail++;
         $display("FAIL full_bs_handshakes: got %0d, required 5", hs_cnt - h0);
      end
      n_cmp++;
      if (chain !== LOAD_PATTERN) begin
         n_fail++;
         $display("FAIL full_chain: got %h, required %h", chain, LOAD_PATTERN);
      end
      n_cmp++;
      if (busy !== 1'b0 || cfg_done !== 1'b1) begin
         n_fail++;
         $display("FAIL full_status: busy=%b cfg_done=%b, required 0/1", busy, cfg_done);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (rd_idx >= obs_cnt) begin
            n_fail++;
            $display("FAIL full_readback: word missing, required %h", e);
         end else begin
            if (obs_mem[rd_idx] !== e) begin
               n_fail++;
               $display("FAIL full_readback: word %0d got %h, required %h", rd_idx, obs_mem[rd_idx], e);
            end
            rd_idx++;
         end
      end
   endtask

   task automatic test_back_pressure();
      int s0, h0;
      logic [7:0] e;
      bit seen;
      preload(LOAD_PATTERN);
      s0 = shift_cnt;
      h0 = hs_cnt;
      rb_ready = 1'b0;
      pulse_start();
      fork
         feed(0);
         begin
            seen = 1'b0;
            for (int i = 0; i < 200 && !seen; i++) begin
               @(negedge prog_clk);
               if (rb_valid) seen = 1'b1;
            end
            for (int j = 0; j < 10; j++) begin
               @(posedge prog_clk); #1;
               n_cmp++;
               if (shift_en !== 1'b0) begin
                  n_fail++;
                  $display("FAIL stall_shift_en: cycle %0d got %b, required 0", j, shift_en);
               end
            end
            n_cmp++;
            if (shift_cnt - s0 !== 8 || hs_cnt - h0 !== 2) begin
               n_fail++;
               $display("FAIL stall_progress: shifts=%0d handshakes=%0d, required 8/2",
                        shift_cnt - s0, hs_cnt - h0);
            end
            rb_ready = 1'b1;
         end
      join
      wait_done("stall");
      n_cmp++;
      if (shift_cnt - s0 !== CHAIN_LEN || chain !== LOAD_PATTERN) begin
         n_fail++;
         $display("FAIL stall_chain: shifts=%0d chain=%h, required %0d/%h",
                  shift_cnt - s0, chain, CHAIN_LEN, LOAD_PATTERN);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (rd_idx >= obs_cnt) begin
            n_fail++;
            $display("FAIL stall_readback: word missing, required %h", e);
         end else begin
            if (obs_mem[rd_idx] !== e) begin
               n_fail++;
               $display("FAIL stall_readback: word %0d got %h, required %h", rd_idx, obs_mem[rd_idx], e);
            end
            rd_idx++;
         end
      end
   endtask

   task automatic test_bs_gaps();
      int s0;
      logic [7:0] e;
      preload(36'hA_DEAD_BEEF);
      s0 = shift_cnt;
      pulse_start();
      feed(3);
      wait_done("gaps");
      n_cmp++;
      if (shift_cnt - s0 !== CHAIN_LEN || chain !== LOAD_PATTERN) begin
         n_fail++;
         $display("FAIL gaps_chain: shifts=%0d chain=%h, required %0d/%h",
                  shift_cnt - s0, chain, CHAIN_LEN, LOAD_PATTERN);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (rd_idx >= obs_cnt) begin
            n_fail++;
            $display("FAIL gaps_readback: word missing, required %h", e);
         end else begin
            if (obs_mem[rd_idx] !== e) begin
               n_fail++;
               $display("FAIL gaps_readback: word %0d got %h, required %h", rd_idx, obs_mem[rd_idx], e);
            end
            rd_idx++;
         end
      end
   endtask

   task automatic test_abort();
      int s0;
      bit reached;
      logic [7:0] e;
      preload(36'h0_1234_5678);
      s0 = shift_cnt;
      aborted = 1'b0;
      pulse_start();
      fork
         feed(0);
         begin
            reached = 1'b0;
            for (int i = 0; i < 200 && !reached; i++) begin
               @(posedge prog_clk); #1;
               if (shift_cnt - s0 >= 17) reached = 1'b1;
            end
            n_cmp++;
            if (!reached) begin
               n_fail++;
               $display("FAIL abort_reach_bit17: shifts=%0d, required 17", shift_cnt - s0);
            end
            abort   = 1'b1;
            start   = 1'b1;
            aborted = 1'b1;
            @(posedge prog_clk); #1;
            abort = 1'b0;
            start = 1'b0;
            n_cmp++;
            if (shift_en !== 1'b0 || rb_valid !== 1'b0 || busy !== 1'b0 || bs_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL abort_idle: shift_en=%b rb_valid=%b busy=%b bs_ready=%b, required 0/0/0/0",
                        shift_en, rb_valid, busy, bs_ready);
            end
         end
      join
      repeat (3) begin
         @(posedge prog_clk); #1;
      end
      n_cmp++;
      if (busy !== 1'b0 || cfg_done !== 1'b0 || bs_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_stays_idle: busy=%b cfg_done=%b bs_ready=%b, required 0/0/0", busy, cfg_done, bs_ready);
      end
      // Only the two words completed before the abort were handed over.
      for (int k = 0; k < 2; k++) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (rd_idx >= obs_cnt || obs_mem[rd_idx] !== e) begin
            n_fail++;
            $display("FAIL abort_readback: word %0d got %h, required %h", k,
                     (rd_idx < obs_cnt) ? obs_mem[rd_idx] : 8'hxx, e);
         end
         rd_idx++;
      end
      n_cmp++;
      if (obs_cnt !== rd_idx) begin
         n_fail++;
         $display("FAIL abort_extra_readback: got %0d words, required %0d", obs_cnt, rd_idx);
      end
      exp_q.delete();
      rd_idx  = obs_cnt;
      aborted = 1'b0;
      // A fresh start after the abort must perform a complete load.
      preload(36'h0_1234_5678);
      s0 = shift_cnt;
      pulse_start();
      feed(0);
      wait_done("reload");
      n_cmp++;
      if (shift_cnt - s0 !== CHAIN_LEN || chain !== LOAD_PATTERN) begin
         n_fail++;
         $display("FAIL reload_chain: shifts=%0d chain=%h, required %0d/%h",
                  shift_cnt - s0, chain, CHAIN_LEN, LOAD_PATTERN);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (rd_idx >= obs_cnt) begin
            n_fail++;
            $display("FAIL reload_readback: word missing, required %h", e);
         end else begin
            if (obs_mem[rd_idx] !== e) begin
               n_fail++;
               $display("FAIL reload_readback: word %0d got %h, required %h", rd_idx, obs_mem[rd_idx], e);
            end
            rd_idx++;
         end
      end
   endtask

   task automatic test_reset_mid_shift();
      int s0;
      bit reached;
      preload(36'h0_1234_5678);
      s0 = shift_cnt;
      aborted = 1'b0;
      pulse_start();
      fork
         feed(0);
         begin
            reached = 1'b0;
            for (int i = 0; i < 200 && !reached; i++) begin
               @(posedge prog_clk); #1;
               if (shift_cnt - s0 >= 12) reached = 1'b1;
            end
            n_cmp++;
            if (!reached || busy !== 1'b1 || rb_data !== 8'h78) begin
               n_fail++;
               $display("FAIL rst_mid_precondition: shifts=%0d busy=%b rb_data=%h, required 12/1/78",
                        shift_cnt - s0, busy, rb_data);
            end
            #3;
            prog_rst_n = 1'b0;
            aborted    = 1'b1;
            #1;
            n_cmp++;
            if ({bs_ready, ccff_head, shift_en, rb_valid, busy, cfg_done} !== 6'b0 || rb_data !== 8'h00) begin
               n_fail++;
               $display("FAIL rst_mid_async: ctrl=%b rb_data=%h, required 000000/00",
                        {bs_ready, ccff_head, shift_en, rb_valid, busy, cfg_done}, rb_data);
            end
         end
      join
      @(posedge prog_clk); #1;
      prog_rst_n = 1'b1;
      repeat (3) begin
         @(posedge prog_clk); #1;
      end
      n_cmp++;
      if (busy !== 1'b0 || bs_ready !== 1'b0 || shift_en !== 1'b0 || cfg_done !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_idle: busy=%b bs_ready=%b shift_en=%b cfg_done=%b, required 0/0/0/0",
                  busy, bs_ready, shift_en, cfg_done);
      end
      exp_q.delete();
      rd_idx  = obs_cnt;
      aborted = 1'b0;
   endtask

   initial begin
      test_reset();
      test_full_load();
      test_back_pressure();
      test_bs_gaps();
      test_abort();
      test_reset_mid_shift();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
